serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: SERIAL_ADDER

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result bit width (legal range 2..32).
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST_N  input  1  reset, synchronous, active-low.
REQ-004 START  input  1  request to begin an addition; sampled on rising CLK.
REQ-005 A  input  WIDTH  operand A; sampled only on an accepted START.
REQ-006 B  input  WIDTH  operand B; sampled only on an accepted START.
REQ-007 CIN  input  1  carry-in; sampled only on an accepted START.
REQ-008 BUSY  output  1  high while an addition is in progress (SHIFT state).
REQ-009 DONE  output  1  single-cycle pulse marking SUM/COUT newly valid.
REQ-010 SUM  output  WIDTH  result A+B+CIN modulo 2^WIDTH.
REQ-011 COUT  output  1  carry-out of bit WIDTH-1.

Function
REQ-012 The block SHALL compute each result bit LSB-first with a single FULL_ADDER instance; carry port H feeds the carry register, and sum port L feeds the result shift register.
REQ-013 State machine SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-014 In IDLE or DONE, START=1 on an edge SHALL be accepted, which means:
- latch A and B into operand shift registers;
- load the carry register with CIN;
- clear the bit counter to 0;
- go to SHIFT.
REQ-015 START SHALL be ignored while in SHIFT; operands and the in-progress result SHALL be unaffected.
REQ-016 Each SHIFT edge SHALL:
- shift one full-adder sum bit into the result register MSB, shifting right;
- update the carry register from H;
- shift both operand registers right;
- increment the counter.
REQ-017 On the SHIFT edge where the counter equals WIDTH-1, the block SHALL:
- go to DONE;
- load SUM from the completed result register;
- load COUT from the final carry.
REQ-018 Latency: with START accepted at edge t0, DONE SHALL be high for exactly the cycle following edge t0+WIDTH.
REQ-019 BUSY SHALL be high in the cycles following edges t0 through t0+WIDTH-1, and low otherwise.
REQ-020 From DONE with no START, the next edge SHALL return the block to IDLE.
REQ-021 SUM and COUT SHALL hold their last result until the next DONE entry; they SHALL NOT change during SHIFT.
REQ-022 START=1 in the DONE cycle SHALL be accepted (back-to-back operation with no idle cycle); DONE SHALL still be exactly one cycle wide.
REQ-023 START held high continuously SHALL start a new addition on every DONE cycle.
REQ-024 Overflow: SUM SHALL wrap modulo 2^WIDTH, with the carry reported only on COUT.
REQ-025 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-026 RST_N=0 on a rising edge SHALL force:
- state to IDLE;
- BUSY=0, DONE=0, SUM=0, COUT=0;
- counter, carry register and operand registers to 0.
REQ-027 Reset SHALL take priority over START and over any SHIFT in progress; an interrupted addition SHALL be discarded with no DONE pulse.
REQ-028 START=1 in the same edge as RST_N=0 SHALL be ignored.
REQ-029 The first START SHALL be accepted on the first edge with RST_N=1.

Verification (WIDTH=8)
REQ-030 Zero case: A=0x00, B=0x00, CIN=0, START one cycle -> DONE exactly 8 cycles after the accept edge, SUM=0x00, COUT=0.
REQ-031 Carry chain: A=0xFF, B=0x01, CIN=0 -> SUM=0x00, COUT=1; A=0x7F, B=0x01, CIN=0 -> SUM=0x80, COUT=0.
REQ-032 Carry-in full propagate: A=0xA5, B=0x5A, CIN=1 -> SUM=0x00, COUT=1; BUSY high for exactly 8 cycles.
REQ-033 START ignored while busy: START with A=0x03, B=0x04, then START with A=0xF0, B=0xF0 on cycle 3 of SHIFT -> single DONE, SUM=0x07, COUT=0.
REQ-034 Back-to-back: START held high with A=0x10, B=0x20, then A=0x01, B=0x01 applied during the DONE cycle -> SUM=0x30 then SUM=0x02, DONE pulses 9 cycles apart.
REQ-035 Reset mid-operation: RST_N=0 on SHIFT cycle 4 -> next cycle all outputs 0 and no DONE; a following A=0x01, B=0x02 addition -> SUM=0x03.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: one full adder processes A+B+CIN one bit per clock,
// starting at the LSB, and presents SUM/COUT with a one-cycle DONE pulse.
//
// Handshake: START is a request sampled on the rising edge. It is accepted
// only in IDLE or DONE, and ignored while BUSY is high. DONE is high for
// exactly one cycle when SUM/COUT take a new value. There is no
// back-pressure: the result is overwritten only by the next DONE.

// Single-bit full adder: h is the carry, l is the sum.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic h,
  output logic l
);
  assign l = a ^ b ^ c;
  assign h = (a & b) | (a & c) | (b & c);
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [1:0]       dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_h;
  logic             fa_l;
  logic             accept;
  logic             last;

  // START counts only outside SHIFT; an in-progress addition is never disturbed.
  assign accept = start && (state != S_SHIFT);
  assign last   = (cnt == LAST);

  full_adder u_fa (
    .a (op_a[0]),
    .b (op_b[0]),
    .c (carry),
    .h (fa_h),
    .l (fa_l)
  );

  // State register; reset wins over everything, including a pending START.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; DONE with START held goes straight back to SHIFT.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_SHIFT;
      S_SHIFT: if (last)  state_nxt = S_DONE;
      S_DONE:  state_nxt = start ? S_SHIFT : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: load on accept, then shift one bit per SHIFT cycle; the last
  // bit is merged directly into SUM so the result appears with DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_a  <= '0;
      op_b  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      op_a  <= a;
      op_b  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == S_SHIFT) begin
      res   <= {fa_l, res[WIDTH-1:1]};
      carry <= fa_h;
      op_a  <= op_a >> 1;
      op_b  <= op_b >> 1;
      cnt   <= cnt + CW'(1);
      if (last) begin
        sum  <= {fa_l, res[WIDTH-1:1]};
        cout <= fa_h;
      end
    end
  end

  // Status outputs decode the state register only, so no input reaches them.
  assign busy      = (state == S_SHIFT);
  assign done      = (state == S_DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8). Drivers push the expected
// {sum,cout} and the expected DONE cycle; a monitor pops on every DONE.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic [1:0]   dbg_state;

  logic [W:0]   exp_q[$];
  int           exp_cyc_q[$];
  int           cyc = 0;
  int           tests_run = 0;
  int           tests_failed = 0;

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .cout      (cout),
    .dbg_state (dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests_run++;
    if (act !== expv) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Queue an expectation for an accept on the coming posedge.
  task automatic expect_result(input logic [W-1:0] ea, input logic [W-1:0] eb, input logic ec);
    logic [W:0] full;
    full = {1'b0, ea} + {1'b0, eb} + {{W{1'b0}}, ec};
    exp_q.push_back({full[W-1:0], full[W]});
    exp_cyc_q.push_back(cyc + 1 + W);
  endtask

  // Drive START for one cycle; returns at the negedge after the accept edge.
  task automatic go(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc);
    @(negedge clk);
    start = 1'b1; a = va; b = vb; cin = vc;
    expect_result(va, vb, vc);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Bounded wait for DONE (sampled on negedge).
  task automatic wait_done();
    int g;
    g = 0;
    while (!done && g < 40) begin
      @(negedge clk);
      g++;
    end
    check("done_timeout", {31'd0, done}, 32'd1);
  endtask

  // Monitor: every DONE pops one expectation and checks value and timing.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_done: got sum=0x%0h cout=%0b expected no DONE (cycle %0d)", sum, cout, cyc);
      end else begin
        logic [W:0] e;
        int ecyc;
        e = exp_q.pop_front();
        ecyc = exp_cyc_q.pop_front();
        check("sum", {24'd0, sum}, {24'd0, e[W:1]});
        check("cout", {31'd0, cout}, {31'd0, e[0]});
        check("done_latency", cyc, ecyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    int n;
    int g;

    // Reset with START high: must be ignored, outputs zero.
    start = 1'b1; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum", {24'd0, sum}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);

    // Zero case: START accepted on the first edge with reset released.
    rst_n = 1'b1;
    expect_result(8'h00, 8'h00, 1'b0);
    @(negedge clk);
    start = 1'b0;
    check("first_accept_busy", {31'd0, busy}, 32'd1);
    wait_done();
    @(negedge clk);

    // Carry chain and wrap.
    go(8'hFF, 8'h01, 1'b0); wait_done(); @(negedge clk);
    go(8'h7F, 8'h01, 1'b0); wait_done(); @(negedge clk);
    go(8'h80, 8'h80, 1'b1); wait_done(); @(negedge clk);
    go(8'h3C, 8'h0F, 1'b1); wait_done(); @(negedge clk);

    // Full carry-in propagate; BUSY exactly W cycles.
    go(8'hA5, 8'h5A, 1'b1);
    n = 0; g = 0;
    while (!done && g < 40) begin
      if (busy) n++;
      @(negedge clk);
      g++;
    end
    check("busy_cycles", n, W);
    check("busy_low_at_done", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 32'd0);

    // START ignored while busy; SUM holds during SHIFT.
    go(8'h03, 8'h04, 1'b0);
    repeat (2) @(negedge clk);
    check("hold_sum_in_shift", {24'd0, sum}, 32'h00);
    check("hold_cout_in_shift", {31'd0, cout}, 32'd1);
    start = 1'b1; a = 8'hF0; b = 8'hF0;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (12) @(negedge clk);

    // Back-to-back with START held high.
    start = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0;
    expect_result(8'h10, 8'h20, 1'b0);
    @(negedge clk);
    wait_done();
    a = 8'h01; b = 8'h01;
    expect_result(8'h01, 8'h01, 1'b0);
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", {31'd0, busy}, 32'd1);
    wait_done();
    @(negedge clk);

    // Reset during SHIFT cycle 4: discarded, no DONE.
    start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_sum", {24'd0, sum}, 32'd0);
    check("midrst_cout", {31'd0, cout}, 32'd0);
    repeat (3) @(negedge clk);
    check("midrst_idle", {30'd0, dbg_state}, 32'd0);
    go(8'h01, 8'h02, 1'b0); wait_done();

    repeat (12) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
